// File: rtl/el2_btb_wr_sched.sv
// Write scheduler for the single BTB write port: full-table invalidate sweeps,
// a one-deep invalidate holding register and a two-entry update FIFO.
module el2_btb_wr_sched #(
   parameter int INDEX_W = 8,
   parameter int TAG_W   = 5,
   parameter int DATA_W  = 22
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               upd_valid,
   output logic               upd_ready,
   input  logic [INDEX_W-1:0] upd_index,
   input  logic [TAG_W-1:0]   upd_tag,
   input  logic [DATA_W-1:0]  upd_data,
   input  logic               inv_valid,
   input  logic [INDEX_W-1:0] inv_index,
   input  logic               flush_all,
   output logic               wr_en,
   output logic [INDEX_W-1:0] wr_index,
   output logic [TAG_W-1:0]   wr_tag,
   output logic [DATA_W-1:0]  wr_data,
   output logic               wr_vld,
   output logic               sweep_busy
);

   typedef enum logic {ST_SWEEP, ST_IDLE} state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [INDEX_W-1:0]   r_cnt;
   logic [INDEX_W-1:0]   w_cnt_next;

   logic                 r_inv_pend;
   logic [INDEX_W-1:0]   r_inv_idx;

   logic [INDEX_W-1:0]   r_f_idx  [2];
   logic [TAG_W-1:0]     r_f_tag  [2];
   logic [DATA_W-1:0]    r_f_data [2];
   logic                 r_rd_ptr;
   logic                 r_wr_ptr;
   logic [1:0]           r_count;

   logic                 w_full;
   logic                 w_push;
   logic                 w_pop;

   assign w_full     = (r_count == 2'd2);
   assign upd_ready  = !rst && (r_state == ST_IDLE) && !w_full && !flush_all;
   assign w_push     = upd_valid && upd_ready;
   assign sweep_busy = rst || (r_state == ST_SWEEP);

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      wr_en        = 1'b0;
      wr_index     = '0;
      wr_tag       = '0;
      wr_data      = '0;
      wr_vld       = 1'b0;
      w_pop        = 1'b0;
      case (r_state)
         ST_SWEEP: begin
            wr_en    = 1'b1;
            wr_index = r_cnt;
            if (r_cnt == '1) begin
               w_state_next = ST_IDLE;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         ST_IDLE: begin
            // A pending invalidate always goes ahead of queued updates.
            if (r_inv_pend) begin
               wr_en    = 1'b1;
               wr_index = r_inv_idx;
            end else if (r_count != 2'd0) begin
               wr_en    = 1'b1;
               wr_index = r_f_idx[r_rd_ptr];
               wr_tag   = r_f_tag[r_rd_ptr];
               wr_data  = r_f_data[r_rd_ptr];
               wr_vld   = 1'b1;
               w_pop    = 1'b1;
            end
         end
         default: begin
            w_state_next = ST_SWEEP;
            w_cnt_next   = '0;
         end
      endcase
      if (flush_all) begin
         w_state_next = ST_SWEEP;
         w_cnt_next   = '0;
      end
      if (rst) begin
         wr_en = 1'b0;
         wr_index = '0;
         wr_tag   = '0;
         wr_data  = '0;
         wr_vld   = 1'b0;
         w_pop    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_SWEEP;
         r_cnt      <= '0;
         r_inv_pend <= 1'b0;
         r_inv_idx  <= '0;
         r_rd_ptr   <= 1'b0;
         r_wr_ptr   <= 1'b0;
         r_count    <= 2'd0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         if (flush_all) begin
            r_inv_pend <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
         end else begin
            // Any pending invalidate is written this cycle, so a new one simply replaces it.
            r_inv_pend <= inv_valid && (r_state == ST_IDLE);
            if (inv_valid) r_inv_idx <= inv_index;
            if (w_push) r_wr_ptr <= !r_wr_ptr;
            if (w_pop)  r_rd_ptr <= !r_rd_ptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_f_idx[r_wr_ptr]  <= upd_index;
         r_f_tag[r_wr_ptr]  <= upd_tag;
         r_f_data[r_wr_ptr] <= upd_data;
      end
   end

endmodule

// File: tb/tb_el2_btb_wr_sched.sv
// Bench for el2_btb_wr_sched: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of the write schedule.
module tb_el2_btb_wr_sched;

   localparam int IW = 8;
   localparam int TW = 5;
   localparam int DW = 22;
   localparam int NENT = 1 << IW;

   logic          clk = 1'b0;
   logic          rst;
   logic          upd_valid;
   logic          upd_ready;
   logic [IW-1:0] upd_index;
   logic [TW-1:0] upd_tag;
   logic [DW-1:0] upd_data;
   logic          inv_valid;
   logic [IW-1:0] inv_index;
   logic          flush_all;
   logic          wr_en;
   logic [IW-1:0] wr_index;
   logic [TW-1:0] wr_tag;
   logic [DW-1:0] wr_data;
   logic          wr_vld;
   logic          sweep_busy;

   always #5 clk = ~clk;

   el2_btb_wr_sched #(.INDEX_W(IW), .TAG_W(TW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .upd_valid(upd_valid), .upd_ready(upd_ready),
      .upd_index(upd_index), .upd_tag(upd_tag), .upd_data(upd_data),
      .inv_valid(inv_valid), .inv_index(inv_index), .flush_all(flush_all),
      .wr_en(wr_en), .wr_index(wr_index), .wr_tag(wr_tag), .wr_data(wr_data),
      .wr_vld(wr_vld), .sweep_busy(sweep_busy)
   );

   typedef struct {
      logic [IW-1:0] idx;
      logic [TW-1:0] tag;
      logic [DW-1:0] data;
   } ent_t;

   // Model: sweep position, pending-invalidate slot and a queue of accepted updates.
   ent_t          m_q[$];
   bit            m_sweep;
   int            m_pos;
   bit            m_invp;
   logic [IW-1:0] m_invidx;

   int n_cmp = 0;
   int n_fail = 0;

   logic          obs_en, obs_vld, obs_busy, obs_rdy;
   logic [IW-1:0] obs_idx;
   logic [TW-1:0] obs_tag;
   logic [DW-1:0] obs_data;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic uv, input logic [IW-1:0] ui,
                       input logic [TW-1:0] ut, input logic [DW-1:0] ud,
                       input logic iv, input logic [IW-1:0] ii, input logic fl);
      logic          e_en, e_vld, e_busy, e_rdy, acc;
      logic [IW-1:0] e_idx;
      logic [TW-1:0] e_tag;
      logic [DW-1:0] e_data;
      ent_t          ne;
      @(posedge clk);
      #1;
      rst = r; upd_valid = uv; upd_index = ui; upd_tag = ut; upd_data = ud;
      inv_valid = iv; inv_index = ii; flush_all = fl;
      @(negedge clk);
      e_en = 1'b0; e_vld = 1'b0; e_idx = '0; e_tag = '0; e_data = '0;
      if (!r) begin
         if (m_sweep) begin
            e_en = 1'b1; e_idx = IW'(m_pos);
         end else if (m_invp) begin
            e_en = 1'b1; e_idx = m_invidx;
         end else if (m_q.size() > 0) begin
            e_en = 1'b1; e_vld = 1'b1;
            e_idx = m_q[0].idx; e_tag = m_q[0].tag; e_data = m_q[0].data;
         end
      end
      e_busy = r || m_sweep;
      e_rdy  = !r && !m_sweep && (m_q.size() < 2) && !fl;
      chk("wr_en", 32'(wr_en), 32'(e_en));
      if (e_en || r) begin
         chk("wr_index", 32'(wr_index), 32'(e_idx));
         chk("wr_tag", 32'(wr_tag), 32'(e_tag));
         chk("wr_data", 32'(wr_data), 32'(e_data));
         chk("wr_vld", 32'(wr_vld), 32'(e_vld));
      end
      chk("sweep_busy", 32'(sweep_busy), 32'(e_busy));
      chk("upd_ready", 32'(upd_ready), 32'(e_rdy));
      obs_en = wr_en; obs_vld = wr_vld; obs_busy = sweep_busy; obs_rdy = upd_ready;
      obs_idx = wr_index; obs_tag = wr_tag; obs_data = wr_data;
      if (wr_en && wr_vld)
         $display("t=%0t update write idx=%02h tag=%02h data=%06h", $time, wr_index, wr_tag, wr_data);

      acc = uv && e_rdy;
      if (r) begin
         m_sweep = 1; m_pos = 0; m_invp = 0; m_q.delete();
      end else if (fl) begin
         m_sweep = 1; m_pos = 0; m_invp = 0; m_q.delete();
      end else if (m_sweep) begin
         if (m_pos == NENT - 1) begin
            m_sweep = 0; m_pos = 0;
         end else begin
            m_pos++;
         end
      end else begin
         if (m_invp) m_invp = 0;
         else if (m_q.size() > 0) void'(m_q.pop_front());
         if (iv) begin
            m_invp = 1; m_invidx = ii;
         end
         if (acc) begin
            ne.idx = ui; ne.tag = ut; ne.data = ud;
            m_q.push_back(ne);
         end
      end
   endtask

   task automatic idle();
      step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
   endtask

   // Steps until sweep_busy drops; reports sweep writes, first index and update writes seen.
   task automatic run_sweep(output int writes, output int first_idx, output int upd_writes);
      writes = 0; first_idx = -1; upd_writes = 0;
      for (int k = 0; k < 400; k++) begin
         idle();
         if (!obs_busy) break;
         if (obs_en && !obs_vld) begin
            if (writes == 0) first_idx = int'(obs_idx);
            writes++;
         end
         if (obs_en && obs_vld) upd_writes++;
      end
      chk("sweep_terminates", 32'(obs_busy), 32'd0);
   endtask

   int nw, fi, uw, accepts;

   initial begin
      rst = 1'b1; upd_valid = 0; upd_index = '0; upd_tag = '0; upd_data = '0;
      inv_valid = 0; inv_index = '0; flush_all = 0;
      m_sweep = 1; m_pos = 0; m_invp = 0; m_invidx = '0;

      // Reset sweep
      step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
      chk("rst_wr_en", 32'(obs_en), 32'd0);
      chk("rst_busy", 32'(obs_busy), 32'd1);
      step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
      run_sweep(nw, fi, uw);
      chk("reset_sweep_len", 32'(nw), 32'd256);
      chk("reset_sweep_first", 32'(fi), 32'd0);
      chk("ready_after_sweep", 32'(obs_rdy), 32'd1);

      // Single update
      step(1'b0, 1'b1, 8'h3A, 5'h15, 22'h2ABCD, 1'b0, '0, 1'b0);
      idle();
      chk("single_en", 32'(obs_en), 32'd1);
      chk("single_idx", 32'(obs_idx), 32'h3A);
      chk("single_tag", 32'(obs_tag), 32'h15);
      chk("single_data", 32'(obs_data), 32'h2ABCD);
      chk("single_vld", 32'(obs_vld), 32'd1);

      // Same-cycle invalidate and update to one index
      step(1'b0, 1'b1, 8'h10, 5'h07, 22'h01234, 1'b1, 8'h10, 1'b0);
      idle();
      chk("conflict_inv_idx", 32'(obs_idx), 32'h10);
      chk("conflict_inv_vld", 32'({obs_en, obs_vld}), 32'b10);
      idle();
      chk("conflict_upd_idx", 32'(obs_idx), 32'h10);
      chk("conflict_upd_vld", 32'({obs_en, obs_vld}), 32'b11);
      idle();

      // Backpressure: invalidates every cycle starve the FIFO
      accepts = 0;
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b1, IW'(8'h40 + k), TW'(k), DW'(22'h100 + k), 1'b1, IW'(8'hC0 + k), 1'b0);
         if (obs_rdy) accepts++;
         if (k > 0) chk("bp_inv_idx", 32'(obs_idx), 32'(8'hC0 + k - 1));
      end
      chk("bp_accepts", 32'(accepts), 32'd2);
      for (int k = 0; k < 5; k++) idle();

      // Flush mid-sweep at counter 100
      step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
      for (int k = 0; k < 300 && m_pos != 100; k++) idle();
      step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
      chk("flush_cycle_idx", 32'(obs_idx), 32'd100);
      run_sweep(nw, fi, uw);
      chk("midflush_first", 32'(fi), 32'd0);
      chk("midflush_len", 32'(nw), 32'd256);

      // Flush in IDLE with two queued updates and a pending invalidate
      step(1'b0, 1'b1, 8'h51, 5'h01, 22'h0AAAA, 1'b1, 8'h61, 1'b0);
      step(1'b0, 1'b1, 8'h52, 5'h02, 22'h0BBBB, 1'b1, 8'h62, 1'b0);
      step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
      chk("idleflush_inv_idx", 32'(obs_idx), 32'h62);
      run_sweep(nw, fi, uw);
      chk("idleflush_first", 32'(fi), 32'd0);
      chk("idleflush_len", 32'(nw), 32'd256);
      uw = 0;
      for (int k = 0; k < 6; k++) begin
         idle();
         if (obs_en && obs_vld) uw++;
      end
      chk("idleflush_dropped", 32'(uw), 32'd0);

      // Random traffic
      for (int k = 0; k < 5000; k++) begin
         step($urandom_range(0, 1499) == 0,
              $urandom_range(0, 2) != 0, IW'($urandom), TW'($urandom), DW'($urandom),
              $urandom_range(0, 3) == 0, IW'($urandom),
              $urandom_range(0, 599) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
